// File: rtl/vga_pkg.sv
// Shared VGA/game constants: on-screen hit rectangles for the start and restart
// buttons, the session-state encoding used by overlay/debug decoders, and a
// half-open rectangle hit test.
package vga_pkg;

   // Start button area (pixels).
   localparam logic [11:0] START_CHAR_XPOS   = 12'd412;
   localparam logic [11:0] START_CHAR_YPOS   = 12'd300;
   localparam logic [11:0] START_AREA_WIDTH  = 12'd200;
   localparam logic [11:0] START_CHAR_HEIGHT = 12'd48;

   // Restart button area on the game-over screen (pixels).
   localparam logic [11:0] RESTART_XPOS   = 12'd440;
   localparam logic [11:0] RESTART_YPOS   = 12'd420;
   localparam logic [11:0] RESTART_WIDTH  = 12'd144;
   localparam logic [11:0] RESTART_HEIGHT = 12'd40;

   // Session controller states, shared so other blocks can decode them.
   typedef enum logic [2:0] {
      GS_START        = 3'd0,
      GS_SYNC_START   = 3'd1,
      GS_RUNNING      = 3'd2,
      GS_SYNC_END     = 3'd3,
      GS_INTERMISSION = 3'd4,
      GS_OVER         = 3'd5
   } game_session_state_t;

   // Half-open hit test; the right/bottom edges are computed in 13 bits so a
   // rectangle touching the 12-bit limit cannot wrap.
   function automatic logic in_rect(
      input logic [11:0] xpos,
      input logic [11:0] ypos,
      input logic [11:0] rx,
      input logic [11:0] ry,
      input logic [11:0] rw,
      input logic [11:0] rh
   );
      logic [12:0] x_end;
      logic [12:0] y_end;
      x_end = {1'b0, rx} + {1'b0, rw};
      y_end = {1'b0, ry} + {1'b0, rh};
      return ({1'b0, xpos} >= {1'b0, rx}) && ({1'b0, xpos} < x_end) &&
             ({1'b0, ypos} >= {1'b0, ry}) && ({1'b0, ypos} < y_end);
   endfunction

endpackage

// File: rtl/game_session_fsm_peer_sync.sv
// Peer rendezvous helper for the session controller. While 'clear' is low it
// accumulates which peers have signalled, and reports 'done' once every peer
// is either seen now, seen earlier, or already lost. With
// GAME_SESSION_TIMEOUT_EN defined, a saturating counter also forces 'done'
// after SYNC_TIMEOUT_CYCLES cycles and reports the still-missing peers on
// 'lost_new' for that one cycle; without it the wait is unbounded.
module peer_sync #(
   parameter int NUM_PEERS           = 1,
   parameter int SYNC_TIMEOUT_CYCLES = 65_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic [NUM_PEERS-1:0] peer_x,
   input  logic [NUM_PEERS-1:0] lost_in,
   output logic                 done,
   output logic [NUM_PEERS-1:0] lost_new
);

   logic [NUM_PEERS-1:0] seen_r;
   logic [NUM_PEERS-1:0] satisfied_s;
   logic                 all_sat_s;

   // A peer arriving on this very cycle counts, so the exit is not delayed.
   assign satisfied_s = seen_r | peer_x | lost_in;
   assign all_sat_s   = &satisfied_s;

   // Sticky record of peers that have signalled since the wait began.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_r <= '0;
      end else if (clear) begin
         seen_r <= '0;
      end else begin
         seen_r <= seen_r | peer_x;
      end
   end

`ifdef GAME_SESSION_TIMEOUT_EN
   localparam int CNT_W = $clog2(SYNC_TIMEOUT_CYCLES) + 1;
   // The counter holds k after the k-th edge in the wait state, so the edge
   // that samples k == LAST is the SYNC_TIMEOUT_CYCLES-th one.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SYNC_TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_r;
   logic             expired_s;

   // Saturating wait-time counter, zeroed whenever no wait is in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired_s = (cnt_r >= CNT_LAST);

   // Finish on full rendezvous or timeout; on timeout flag the missing peers.
   always_comb begin
      done     = all_sat_s | expired_s;
      lost_new = '0;
      if (expired_s && !all_sat_s) begin
         lost_new = ~satisfied_s;
      end else begin
         lost_new = '0;
      end
   end
`else
   // Without a timeout the wait only ends on a full rendezvous.
   always_comb begin
      done     = all_sat_s;
      lost_new = '0;
   end
`endif

endmodule

// File: rtl/game_session_fsm.sv
// Duck Hunt game-session controller: start screen, start rendezvous with the
// linked peers, NUM_ROUNDS rounds separated by intermissions, end-of-round
// rendezvous and a game-over screen with restart. All outputs are registered
// and derived from the next state, so they change on the same edge as it.
// Optional feature macro: GAME_SESSION_TIMEOUT_EN (peer wait timeout and
// sticky peers_lost flags; without it peers_lost stays 0).
module game_session_fsm
   import vga_pkg::*;
#(
   parameter int NUM_PEERS           = 1,
   parameter int NUM_ROUNDS          = 3,
   parameter int SYNC_TIMEOUT_CYCLES = 65_000_000,
   parameter int INTERMISSION_CYCLES = 32_500_000,
   parameter int ROUND_W             = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 left_mouse,
   input  logic [11:0]          mouse_xpos,
   input  logic [11:0]          mouse_ypos,
   input  logic                 round_finished,
   input  logic [NUM_PEERS-1:0] peer_start,
   input  logic [NUM_PEERS-1:0] peer_ended,
   output logic                 start_pressed,
   output logic                 game_ended,
   output logic                 start_screen_enable,
   output logic                 game_enable,
   output logic                 game_end_enable,
   output logic                 round_start,
   output logic [ROUND_W-1:0]   round_idx,
   output logic [NUM_PEERS-1:0] peers_lost
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   localparam int IC_W = $clog2(INTERMISSION_CYCLES) + 1;
   // Counter holds k after the k-th edge in INTERMISSION; leaving on the edge
   // that samples LAST makes the pause exactly INTERMISSION_CYCLES long.
   localparam logic [IC_W-1:0] IC_LAST = IC_W'(INTERMISSION_CYCLES - 1);
   localparam logic [IC_W-1:0] IC_MAX  = IC_W'(INTERMISSION_CYCLES);

   game_session_state_t state_r;
   game_session_state_t state_nx;

   logic [ROUND_W-1:0]   round_idx_nx;
   logic [NUM_PEERS-1:0] peers_lost_nx;
   logic                 left_prev_r;
   logic [IC_W-1:0]      inter_cnt_r;

   logic                 click_start_s;
   logic                 click_restart_s;
   logic                 inter_done_s;
   logic                 sync_clear_s;
   logic [NUM_PEERS-1:0] sync_peer_s;
   logic                 sync_done_s;
   logic [NUM_PEERS-1:0] sync_lost_new_s;

   // Previous button level for edge detection. It comes out of reset as
   // "pressed" so a button already held during reset never counts as a click.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         left_prev_r <= 1'b1;
      end else begin
         left_prev_r <= left_mouse;
      end
   end

   assign click_start_s = left_mouse && !left_prev_r &&
      in_rect(mouse_xpos, mouse_ypos, START_CHAR_XPOS, START_CHAR_YPOS,
              START_AREA_WIDTH, START_CHAR_HEIGHT);
   assign click_restart_s = left_mouse && !left_prev_r &&
      in_rect(mouse_xpos, mouse_ypos, RESTART_XPOS, RESTART_YPOS,
              RESTART_WIDTH, RESTART_HEIGHT);

   // Saturating intermission timer, held at zero outside INTERMISSION.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inter_cnt_r <= '0;
      end else if (state_r != GS_INTERMISSION) begin
         inter_cnt_r <= '0;
      end else if (inter_cnt_r != IC_MAX) begin
         inter_cnt_r <= inter_cnt_r + IC_W'(1);
      end else begin
         inter_cnt_r <= inter_cnt_r;
      end
   end

   assign inter_done_s = (state_r == GS_INTERMISSION) && (inter_cnt_r >= IC_LAST);

   // Route the relevant peer flags into the single shared rendezvous unit.
   always_comb begin
      sync_peer_s = '0;
      case (state_r)
         GS_SYNC_START: sync_peer_s = peer_start;
         GS_SYNC_END:   sync_peer_s = peer_ended;
         default:       sync_peer_s = '0;
      endcase
   end

   // The rendezvous state restarts whenever no sync state is active, which
   // gives every SYNC_START/SYNC_END entry a clean 'seen' set and timer.
   assign sync_clear_s = (state_r != GS_SYNC_START) && (state_r != GS_SYNC_END);

   peer_sync #(
      .NUM_PEERS          (NUM_PEERS),
      .SYNC_TIMEOUT_CYCLES(SYNC_TIMEOUT_CYCLES)
   ) u_peer_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (sync_clear_s),
      .peer_x  (sync_peer_s),
      .lost_in (peers_lost),
      .done    (sync_done_s),
      .lost_new(sync_lost_new_s)
   );

   // Next-state, round index and lost-peer bookkeeping.
   always_comb begin
      state_nx      = state_r;
      round_idx_nx  = round_idx;
      peers_lost_nx = peers_lost;
      case (state_r)
         GS_START: begin
            if (click_start_s) begin
               state_nx = GS_SYNC_START;
            end else begin
               state_nx = GS_START;
            end
         end
         GS_SYNC_START: begin
            if (sync_done_s) begin
               state_nx      = GS_RUNNING;
               peers_lost_nx = peers_lost | sync_lost_new_s;
            end else begin
               state_nx = GS_SYNC_START;
            end
         end
         GS_RUNNING: begin
            if (round_finished) begin
               state_nx = GS_SYNC_END;
            end else begin
               state_nx = GS_RUNNING;
            end
         end
         GS_SYNC_END: begin
            if (sync_done_s) begin
               peers_lost_nx = peers_lost | sync_lost_new_s;
               if (round_idx == LAST_ROUND) begin
                  state_nx = GS_OVER;
               end else begin
                  state_nx = GS_INTERMISSION;
               end
            end else begin
               state_nx = GS_SYNC_END;
            end
         end
         GS_INTERMISSION: begin
            if (inter_done_s) begin
               state_nx     = GS_RUNNING;
               round_idx_nx = round_idx + ROUND_W'(1);
            end else begin
               state_nx = GS_INTERMISSION;
            end
         end
         GS_OVER: begin
            if (click_restart_s) begin
               state_nx = GS_START;
            end else begin
               state_nx = GS_OVER;
            end
         end
         default: begin
            state_nx = GS_START;
         end
      endcase
      // Entering (or staying in) START wipes the per-game history.
      if (state_nx == GS_START) begin
         round_idx_nx  = '0;
         peers_lost_nx = '0;
      end else begin
         round_idx_nx  = round_idx_nx;
         peers_lost_nx = peers_lost_nx;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= GS_START;
      end else begin
         state_r <= state_nx;
      end
   end

   // Registered outputs, decoded from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_screen_enable <= 1'b1;
         start_pressed       <= 1'b0;
         game_enable         <= 1'b0;
         game_ended          <= 1'b0;
         game_end_enable     <= 1'b0;
         round_start         <= 1'b0;
         round_idx           <= '0;
         peers_lost          <= '0;
      end else begin
         start_screen_enable <= (state_nx == GS_START);
         start_pressed       <= (state_nx == GS_SYNC_START);
         game_enable         <= (state_nx == GS_RUNNING);
         game_ended          <= (state_nx == GS_SYNC_END);
         game_end_enable     <= (state_nx == GS_OVER);
         round_start         <= (state_nx == GS_RUNNING) && (state_r != GS_RUNNING);
         round_idx           <= round_idx_nx;
         // With the timeout compiled out lost_new is constant zero, so this
         // register never leaves its reset value.
         peers_lost          <= peers_lost_nx;
      end
   end

endmodule

// File: tb/tb_game_session_fsm.sv
// Self-checking bench for game_session_fsm (NUM_PEERS=2, NUM_ROUNDS=3,
// SYNC_TIMEOUT_CYCLES=16, INTERMISSION_CYCLES=4). A phase-level reference
// model is stepped on every clock edge and all outputs are compared each
// cycle; directed steps add explicit checks of the documented behaviour.
// Timeout-specific steps follow GAME_SESSION_TIMEOUT_EN.
module tb_game_session_fsm;
   import vga_pkg::*;

   localparam int NP = 2;
   localparam int NR = 3;
   localparam int TO = 16;
   localparam int IC = 4;
   localparam int RW = 2;

   localparam int M_START = 0, M_SYNC_S = 1, M_RUN = 2, M_SYNC_E = 3, M_INTER = 4, M_OVER = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          left_mouse;
   logic [11:0]   mouse_xpos;
   logic [11:0]   mouse_ypos;
   logic          round_finished;
   logic [NP-1:0] peer_start;
   logic [NP-1:0] peer_ended;
   logic          start_pressed;
   logic          game_ended;
   logic          start_screen_enable;
   logic          game_enable;
   logic          game_end_enable;
   logic          round_start;
   logic [RW-1:0] round_idx;
   logic [NP-1:0] peers_lost;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int       ph;
   int       m_round;
   logic [1:0] m_lost;
   logic [1:0] m_seen;
   int       m_wait;
   int       m_inter;
   bit       m_prev;
   logic [5:0] e_flags;

   always #5 clk = ~clk;

   game_session_fsm #(
      .NUM_PEERS          (NP),
      .NUM_ROUNDS         (NR),
      .SYNC_TIMEOUT_CYCLES(TO),
      .INTERMISSION_CYCLES(IC)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .left_mouse         (left_mouse),
      .mouse_xpos         (mouse_xpos),
      .mouse_ypos         (mouse_ypos),
      .round_finished     (round_finished),
      .peer_start         (peer_start),
      .peer_ended         (peer_ended),
      .start_pressed      (start_pressed),
      .game_ended         (game_ended),
      .start_screen_enable(start_screen_enable),
      .game_enable        (game_enable),
      .game_end_enable    (game_end_enable),
      .round_start        (round_start),
      .round_idx          (round_idx),
      .peers_lost         (peers_lost)
   );

   function automatic bit in_box(input int x, input int y, input int bx, input int by,
                                 input int bw, input int bh);
      return (x >= bx) && (x < bx + bw) && (y >= by) && (y < by + bh);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs applied this cycle.
   task automatic model_step();
      bit         click_s, click_r, leave, rs;
      logic [1:0] px, sat;
      int         nph;
      leave = 1'b0;
      rs    = 1'b0;
      if (!rst_n) begin
         ph = M_START; m_round = 0; m_lost = 2'b00; m_seen = 2'b00;
         m_wait = 0; m_inter = 0; m_prev = 1'b1;
         e_flags = 6'b100000;
      end else begin
         click_s = left_mouse && !m_prev && in_box(mouse_xpos, mouse_ypos,
                   START_CHAR_XPOS, START_CHAR_YPOS, START_AREA_WIDTH, START_CHAR_HEIGHT);
         click_r = left_mouse && !m_prev && in_box(mouse_xpos, mouse_ypos,
                   RESTART_XPOS, RESTART_YPOS, RESTART_WIDTH, RESTART_HEIGHT);
         nph = ph;
         case (ph)
            M_START: if (click_s) nph = M_SYNC_S;
            M_SYNC_S, M_SYNC_E: begin
               px  = (ph == M_SYNC_S) ? peer_start : peer_ended;
               sat = m_seen | px | m_lost;
               m_wait++;
               if (sat == 2'b11) leave = 1'b1;
`ifdef GAME_SESSION_TIMEOUT_EN
               else if (m_wait == TO) begin
                  m_lost = m_lost | ~sat;
                  leave  = 1'b1;
               end
`endif
               if (leave) begin
                  m_seen = 2'b00;
                  m_wait = 0;
                  if (ph == M_SYNC_S) nph = M_RUN;
                  else if (m_round == NR - 1) nph = M_OVER;
                  else nph = M_INTER;
               end else begin
                  m_seen = m_seen | px;
               end
            end
            M_RUN: if (round_finished) nph = M_SYNC_E;
            M_INTER: begin
               m_inter++;
               if (m_inter == IC) begin
                  m_inter = 0;
                  m_round++;
                  nph = M_RUN;
               end
            end
            M_OVER: if (click_r) begin
               nph = M_START; m_round = 0; m_lost = 2'b00;
            end
            default: nph = M_START;
         endcase
         rs     = (nph == M_RUN) && (ph != M_RUN);
         m_prev = left_mouse;
         ph     = nph;
         e_flags = {ph == M_START, ph == M_SYNC_S, ph == M_RUN, ph == M_SYNC_E, ph == M_OVER, rs};
      end
   endtask

   // One clock: model follows the edge, DUT outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("flags", {26'd0, start_screen_enable, start_pressed, game_enable, game_ended,
                    game_end_enable, round_start}, {26'd0, e_flags});
      chk("round_idx", 32'(round_idx), 32'(m_round));
      chk("peers_lost", 32'(peers_lost), 32'(m_lost));
   endtask

   task automatic cursor_start();
      mouse_xpos = START_CHAR_XPOS + 12'($urandom_range(0, int'(START_AREA_WIDTH) - 1));
      mouse_ypos = START_CHAR_YPOS + 12'($urandom_range(0, int'(START_CHAR_HEIGHT) - 1));
   endtask

   task automatic cursor_restart();
      mouse_xpos = RESTART_XPOS + 12'($urandom_range(0, int'(RESTART_WIDTH) - 1));
      mouse_ypos = RESTART_YPOS + 12'($urandom_range(0, int'(RESTART_HEIGHT) - 1));
   endtask

   // Release, then press inside a rectangle; returns after the click edge.
   task automatic click(input bit restart);
      left_mouse = 1'b0;
      cycle();
      if (restart) cursor_restart(); else cursor_start();
      left_mouse = 1'b1;
      cycle();
      left_mouse = 1'b0;
   endtask

   task automatic wait_running(input string tag);
      int n;
      n = 0;
      while (game_enable !== 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      chk(tag, 32'(game_enable), 32'd1);
   endtask

   initial begin
      int n;
      bit got;

      // Reset with the button held and the cursor on the start button.
      rst_n = 1'b0; left_mouse = 1'b1; round_finished = 1'b0;
      peer_start = 2'b00; peer_ended = 2'b00;
      mouse_xpos = START_CHAR_XPOS + 12'd5; mouse_ypos = START_CHAR_YPOS + 12'd5;
      cycle(); cycle();
      chk("rst_screen", 32'(start_screen_enable), 32'd1);
      chk("rst_game", 32'(game_enable), 32'd0);
      chk("rst_round", 32'(round_idx), 32'd0);
      rst_n = 1'b1;
      repeat (5) cycle();
      chk("held_no_click", 32'(start_pressed), 32'd0);

      // Click exactly one pixel past the right edge: ignored.
      left_mouse = 1'b0; cycle();
      mouse_xpos = START_CHAR_XPOS + START_AREA_WIDTH; left_mouse = 1'b1; cycle();
      chk("outside_click", 32'(start_screen_enable), 32'd1);

      // Real click: start_pressed on the next cycle.
      click(1'b0);
      chk("click_start", 32'(start_pressed), 32'd1);

      // Both peers start together after a random delay.
      repeat ($urandom_range(0, 5)) cycle();
      peer_start = 2'b11; cycle(); peer_start = 2'b00;
      chk("first_round_start", 32'(round_start), 32'd1);
      chk("first_enable", 32'(game_enable), 32'd1);
      cycle();
      chk("round_start_drop", 32'(round_start), 32'd0);

      // Three rounds, all peers ending together.
      for (int r = 0; r < NR; r++) begin
         repeat ($urandom_range(1, 6)) cycle();
         round_finished = 1'b1; cycle(); round_finished = 1'b0;
         chk("sync_end", 32'(game_ended), 32'd1);
         repeat ($urandom_range(0, 3)) cycle();
         peer_ended = 2'b11; cycle(); peer_ended = 2'b00;
         if (r < NR - 1) begin
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
               round_finished = (n == 1);   // must be ignored in intermission
               cycle();
               n++;
               got = (round_start === 1'b1);
            end
            round_finished = 1'b0;
            chk("inter_len", 32'(n), 32'(IC));
            chk("round_next", 32'(round_idx), 32'(r + 1));
         end else begin
            chk("game_over", 32'(game_end_enable), 32'd1);
         end
      end
      click(1'b1);
      chk("restart", 32'(start_screen_enable), 32'd1);

      // Start rendezvous where peer 1 never shows up.
      click(1'b0);
      peer_start = 2'b01;
`ifdef GAME_SESSION_TIMEOUT_EN
      n = 0;
      while (game_enable !== 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      chk("timeout_len", 32'(n), 32'(TO));
      chk("timeout_lost", 32'(peers_lost), 32'd2);
`else
      repeat (20) cycle();
      chk("wait_forever", 32'(start_pressed), 32'd1);
      peer_start = 2'b11; cycle();
      chk("late_peer", 32'(game_enable), 32'd1);
`endif
      peer_start = 2'b00;
      repeat ($urandom_range(1, 4)) cycle();
      round_finished = 1'b1; cycle(); round_finished = 1'b0;
`ifdef GAME_SESSION_TIMEOUT_EN
      peer_ended = 2'b01;
`else
      peer_ended = 2'b11;
`endif
      cycle(); peer_ended = 2'b00;
      chk("end_one_peer", 32'(game_ended), 32'd0);
      wait_running("round1_run");
      chk("round1_idx", 32'(round_idx), 32'd1);

      // Reset pulse mid-round.
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      chk("midrst_screen", 32'(start_screen_enable), 32'd1);
      chk("midrst_game", 32'(game_enable), 32'd0);
      chk("midrst_round", 32'(round_idx), 32'd0);
      chk("midrst_lost", 32'(peers_lost), 32'd0);

      // Peer 1 arrives exactly on the timeout edge.
      click(1'b0);
      peer_start = 2'b01; cycle(); peer_start = 2'b00;
      repeat (TO - 2) cycle();
      peer_start = 2'b10; cycle(); peer_start = 2'b00;
      chk("arrive_lost", 32'(peers_lost), 32'd0);
      chk("arrive_run", 32'(game_enable), 32'd1);

      // Finish this game with peer 1 silent at the end of each round.
      for (int r = 0; r < NR; r++) begin
         wait_running("game2_run");
         repeat ($urandom_range(1, 4)) cycle();
         round_finished = 1'b1; cycle(); round_finished = 1'b0;
`ifdef GAME_SESSION_TIMEOUT_EN
         peer_ended = 2'b01;
`else
         peer_ended = 2'b11;
`endif
         n = 0;
         while (game_ended === 1'b1 && n < 40) begin
            cycle();
            n++;
         end
         peer_ended = 2'b00;
      end
      chk("game2_over", 32'(game_end_enable), 32'd1);
`ifdef GAME_SESSION_TIMEOUT_EN
      chk("game2_lost", 32'(peers_lost), 32'd2);
`endif
      click(1'b1);
      chk("restart_screen", 32'(start_screen_enable), 32'd1);
      chk("restart_lost", 32'(peers_lost), 32'd0);

      // Random soak against the model.
      for (int i = 0; i < 400; i++) begin
         rst_n      = ($urandom_range(0, 99) != 0);
         left_mouse = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       cursor_start();
            1:       cursor_restart();
            default: begin
               mouse_xpos = 12'($urandom);
               mouse_ypos = 12'($urandom);
            end
         endcase
         round_finished = ($urandom_range(0, 3) == 0);
         peer_start     = 2'($urandom);
         peer_ended     = 2'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
